datapath_ctrl: RTL and testbench
================================

// Module: datapath_ctrl
// PURPOSE
// - Sequencer directly upstream of the 8-bit bus mux. Drives its 5-bit select and the register-file write enables.
// - Accepts one 8-bit instruction at a time over a valid/ready handshake.
// - Steps the mux through the bus transfers each instruction needs: register move, load from din, ALU operand/result, output.
// - Handshakes the ALU with start/done.
// PARAMETERS
// - TIMEOUT  15  ALU_WAIT watchdog limit in cycles (1..255); used only with DATAPATH_CTRL_TIMEOUT_EN
// PORTS
// - clk          in   1  single clock; all state changes on rising edge
// - rst          in   1  synchronous, active-high reset
// - instr        in   8  [7:6] opcode, [5:3] rd, [2:0] rs
// - instr_valid  in   1  instr is valid this cycle
// - instr_ready  out  1  controller can accept instr
// - alu_done     in   1  ALU result is valid on fout; single-cycle pulse
// - sel          out  5  mux select: {r,2'b00} = r0..r7; 5'b00010 = din; 5'b00001 = fout
// - reg_we       out  8  one-hot register write enable; bus value captured at the clk edge
// - alu_lda      out  1  ALU latches operand A from the bus
// - alu_ldb      out  1  ALU latches operand B from the bus
// - alu_start    out  1  single-cycle pulse; starts the ALU operation
// - out_strobe   out  1  the bus carries the OUT value this cycle
// - busy         out  1  high in every state except IDLE
// - err          out  1  single-cycle pulse on ALU timeout; tied 0 without the macro
// BEHAVIOUR
// - Reset: state=IDLE; sel=5'b00000; reg_we=0; all pulse outputs 0; instr_ready=1; busy=0; watchdog counter=0.
// - Handshake: instr_ready=1 only in IDLE. Transfer occurs when instr_valid && instr_ready at a clk edge.
//   - On transfer, instr is latched and the next state is set from the opcode.
//   - instr is ignored in every other state.
// - All outputs are registered as Moore outputs of the state. Default outside the listed states: sel=5'b00000, enables 0.
// - Only the ten legal sel codes are ever driven.
// - States (entry from IDLE on transfer):
//   - MOV (op 00): sel={rs,00}, reg_we[rd]=1 -> IDLE
//   - LDI (op 01): sel=5'b00010, reg_we[rd]=1 -> IDLE
//   - ALU_A (op 10): sel={rd,00}, alu_lda=1 -> ALU_B
//   - ALU_B: sel={rs,00}, alu_ldb=1, alu_start=1 -> ALU_WAIT
//   - ALU_WAIT: sel=5'b00001, no enables. Stays until alu_done=1 -> WB.
//   - WB: sel=5'b00001, reg_we[rd]=1 -> IDLE
//   - OUT (op 11): sel={rs,00}, out_strobe=1 -> IDLE
// - Latency, counted as cycles from the transfer edge back to instr_ready=1:
//   - MOV, LDI, OUT: 2 cycles
//   - ALU: 4 + (cycles spent waiting in ALU_WAIT)
// - rd==rs is legal (MOV r3,r3 rewrites r3 with its own value; ALU uses the same register for both operands).
// - alu_done outside ALU_WAIT is ignored; it is not stored.
// - Reset mid-operation: returns to IDLE next edge, any pending write is dropped, reg_we=0 in the reset cycle.
// - Back-to-back: the next instr may transfer on the first cycle that instr_ready returns high. No bubble beyond IDLE.
// CONFIGURATION
// - DATAPATH_CTRL_TIMEOUT_EN defined:
//   - An 8-bit counter clears on entry to ALU_WAIT and increments each cycle in ALU_WAIT.
//   - When the counter reaches TIMEOUT without alu_done: go to IDLE, err=1 for one cycle, no reg_we.
//   - alu_done in the same cycle as expiry wins: go to WB, err stays 0.
// - DATAPATH_CTRL_TIMEOUT_EN undefined:
//   - No counter; ALU_WAIT waits indefinitely; err is constant 0.
// TESTING
// - Reset with instr_valid=1 -> outputs at reset values; no transfer while rst=1; instr_ready=1 after rst drops.
// - instr=8'b00_010_101 (MOV r2<-r5) -> next cycle sel=5'b10100, reg_we=8'h04; instr_ready=1 the cycle after.
// - instr=8'b01_111_000 (LDI r7) -> sel=5'b00010, reg_we=8'h80 for exactly 1 cycle.
// - instr=8'b10_001_110, alu_done 3 cycles after alu_start:
//   - cycle 1: sel=00100, alu_lda
//   - cycle 2: sel=11000, alu_ldb, alu_start
//   - cycle 3: sel=00001 held while waiting
//   - after done: WB with reg_we=8'h02
// - With macro, TIMEOUT=4, alu_done never asserted -> err pulses once after 4 ALU_WAIT cycles, reg_we stays 0, IDLE.
//   - Repeat with alu_done on the expiry cycle -> WB, err=0.
// - rst asserted during ALU_WAIT -> IDLE next edge; reg_we never asserts; a new instr is accepted immediately.

Source files
------------

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: instruction sequencer driving the bus mux select, register writes and ALU handshake.
// Optional ALU_WAIT watchdog enabled by defining DATAPATH_CTRL_TIMEOUT_EN.
module datapath_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       alu_done,
  output logic [4:0] sel,
  output logic [7:0] reg_we,
  output logic       alu_lda,
  output logic       alu_ldb,
  output logic       alu_start,
  output logic       out_strobe,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, MOV, LDI, ALU_A, ALU_B, ALU_WAIT, WB, OUT} state_t;
  state_t state, nxt;
  logic [5:0] ir;
  logic [2:0] rd, rs;
  logic expire;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("datapath_ctrl: TIMEOUT must be in 1..255");
  end
  // Register fields come straight from the input on the transfer edge, from the latch afterwards.
  assign rd = state == IDLE ? instr[5:3] : ir[5:3];
  assign rs = state == IDLE ? instr[2:0] : ir[2:0];
`ifdef DATAPATH_CTRL_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = state == ALU_WAIT && !alu_done && cnt + 8'd1 == 8'(TIMEOUT);
  always_ff @(posedge clk) begin
    cnt <= rst || state != ALU_WAIT ? 8'd0 : cnt + 8'd1;
    err <= !rst && expire;
  end
`else
  assign expire = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = !instr_valid ? IDLE : instr[7:6] == 2'b00 ? MOV : instr[7:6] == 2'b01 ? LDI :
                      instr[7:6] == 2'b10 ? ALU_A : OUT;
      ALU_A:    nxt = ALU_B;
      ALU_B:    nxt = ALU_WAIT;
      ALU_WAIT: nxt = alu_done ? WB : expire ? IDLE : ALU_WAIT;
      default:  nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the state being entered so they line up with it as registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ir          <= '0;
      sel         <= '0;
      reg_we      <= '0;
      alu_lda     <= 1'b0;
      alu_ldb     <= 1'b0;
      alu_start   <= 1'b0;
      out_strobe  <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      state       <= nxt;
      ir          <= state == IDLE && instr_valid ? instr[5:0] : ir;
      sel         <= nxt inside {MOV, ALU_B, OUT} ? {rs, 2'b00} : nxt == ALU_A ? {rd, 2'b00} :
                     nxt == LDI ? 5'b00010 : nxt inside {ALU_WAIT, WB} ? 5'b00001 : 5'b00000;
      reg_we      <= nxt inside {MOV, LDI, WB} ? 8'd1 << rd : 8'd0;
      alu_lda     <= nxt == ALU_A;
      alu_ldb     <= nxt == ALU_B;
      alu_start   <= nxt == ALU_B;
      out_strobe  <= nxt == OUT;
      busy        <= nxt != IDLE;
      instr_ready <= nxt == IDLE;
    end
  end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table vectors, corner sequences and random instructions checked against a cycle-list model.
module tb_datapath_ctrl;
  localparam int T = 4;
`ifdef DATAPATH_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, instr_valid, instr_ready, alu_done, alu_lda, alu_ldb, alu_start, out_strobe, busy, err;
  logic [7:0] instr, reg_we;
  logic [4:0] sel;
  datapath_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_done(alu_done), .sel(sel), .reg_we(reg_we), .alu_lda(alu_lda), .alu_ldb(alu_ldb),
    .alu_start(alu_start), .out_strobe(out_strobe), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] we;
    logic lda, ldb, start, strobe, busy, ready, err;
  } obs_t;
  typedef struct {
    logic [7:0] i;
    int         d;
    logic [4:0] first_sel;
    logic [7:0] last_we;
  } vec_t;
  obs_t q[$];
  bit dq[$];
  bit exp_err, err_after;
  int checks = 0, errors = 0;
  logic [4:0] first_sel;
  logic [7:0] last_we;
  vec_t vecs[6];
  function automatic obs_t now();
    return {sel, reg_we, alu_lda, alu_ldb, alu_start, out_strobe, busy, instr_ready, err};
  endfunction
  function automatic obs_t mk(logic [4:0] s, logic [7:0] w, logic a, logic b, logic st, logic ob);
    return {s, w, a, b, st, ob, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic obs_t idle(logic e);
    return {5'd0, 8'd0, 4'b0000, 1'b0, 1'b1, e};
  endfunction
  function automatic logic [7:0] onehot(logic [2:0] r);
    return 8'(2 ** r);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic idle_check(input string name);
    chk(name, 32'(now()), 32'(idle(exp_err)));
    exp_err = 1'b0;
  endtask
  // Expected busy cycles of one instruction; d = WAIT cycle (1-based) on which alu_done arrives.
  task automatic build(input logic [7:0] i, input int d);
    int waits;
    logic [2:0] rd, rs;
    rd = i[5:3];
    rs = i[2:0];
    q.delete();
    dq.delete();
    err_after = 1'b0;
    case (i[7:6])
      2'b00: q.push_back(mk({rs, 2'b00}, onehot(rd), 0, 0, 0, 0));
      2'b01: q.push_back(mk(5'b00010, onehot(rd), 0, 0, 0, 0));
      2'b11: q.push_back(mk({rs, 2'b00}, 8'd0, 0, 0, 0, 1));
      default: begin
        q.push_back(mk({rd, 2'b00}, 8'd0, 1, 0, 0, 0));
        q.push_back(mk({rs, 2'b00}, 8'd0, 0, 1, 1, 0));
        dq.push_back(1'($urandom_range(0, 1)));
        dq.push_back(1'($urandom_range(0, 1)));
        waits = TO_EN && d > T ? T : d;
        for (int w = 1; w <= waits; w++) begin
          q.push_back(mk(5'b00001, 8'd0, 0, 0, 0, 0));
          dq.push_back(w == d);
        end
        if (TO_EN && d > T) err_after = 1'b1;
        else q.push_back(mk(5'b00001, onehot(rd), 0, 0, 0, 0));
      end
    endcase
    while (dq.size() < q.size()) dq.push_back(1'($urandom_range(0, 1)));
  endtask
  task automatic run(input logic [7:0] i, input int d);
    idle_check("idle_before");
    instr = i;
    instr_valid = 1'b1;
    alu_done = 1'($urandom_range(0, 1));
    build(i, d);
    foreach (q[k]) begin
      @(negedge clk);
      chk("seq", 32'(now()), 32'(q[k]));
      if (k == 0) first_sel = sel;
      last_we = reg_we;
      instr = 8'($urandom);
      instr_valid = 1'($urandom_range(0, 1));
      alu_done = dq[k];
    end
    instr_valid = 1'b0;
    alu_done = 1'b0;
    @(negedge clk);
    exp_err = err_after;
  endtask
  initial begin
    vecs[0] = '{8'b00_010_101, 1, 5'b10100, 8'h04};
    vecs[1] = '{8'b01_111_000, 1, 5'b00010, 8'h80};
    vecs[2] = '{8'b10_001_110, 3, 5'b00100, 8'h02};
    vecs[3] = '{8'b11_000_011, 1, 5'b01100, 8'h00};
    vecs[4] = '{8'b00_011_011, 1, 5'b01100, 8'h08};
    vecs[5] = '{8'b10_101_101, 1, 5'b10100, 8'h20};
    exp_err = 1'b0;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = 8'b00_010_101;
    alu_done = 1'b1;
    repeat (2) @(negedge clk);
    idle_check("reset");
    @(negedge clk);
    idle_check("reset_hold");
    rst = 1'b0;
    instr_valid = 1'b0;
    alu_done = 1'b0;
    @(negedge clk);
    foreach (vecs[v]) begin
      run(vecs[v].i, vecs[v].d);
      chk("first_sel", 32'(first_sel), 32'(vecs[v].first_sel));
      chk("last_we", 32'(last_we), 32'(vecs[v].last_we));
    end
    if (TO_EN) begin
      run(8'b10_010_001, T + 1);
      chk("timeout_we", 32'(last_we), 32'h0);
      run(8'b10_010_001, T);
      chk("expiry_done_we", 32'(last_we), 32'h04);
    end else begin
      run(8'b10_010_001, 20);
      chk("long_wait_we", 32'(last_we), 32'h04);
    end
    idle_check("pre_reset_mid");
    instr = 8'b10_100_010;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_wait_sel", 32'(sel), 32'b00001);
    rst = 1'b1;
    @(negedge clk);
    idle_check("reset_mid_wait");
    rst = 1'b0;
    instr = 8'b00_110_001;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("after_reset_mov", 32'(now()), 32'(mk(5'b00100, 8'h40, 0, 0, 0, 0)));
    instr_valid = 1'b0;
    @(negedge clk);
    repeat (200) begin
      repeat ($urandom_range(0, 2)) begin
        idle_check("gap");
        @(negedge clk);
      end
      run(8'($urandom), int'($urandom_range(1, TO_EN ? T + 2 : 6)));
    end
    idle_check("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
